uart_receiver: RTL and testbench

//   8N1 UART receive path. Oversamples the serial line with the system clock,

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_receiver.sv | 123 ++++++++++++
 tb/tb_uart_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with parameterised reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first one a full cycle to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, mid-bit sampling; frame_err_o with UART_RX_FRAME_ERR_EN
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                      frame_err_o
`endif
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  logic [CW-1:0]             baud_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_s;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // Frame FSM: half-bit wait to reach mid start bit, then one full bit period per sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_o <= 1'b0;
`endif
    end else begin
      valid_o     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= HALF_LOAD;
          end
        end

        START: begin
          if (baud_cnt == '0) begin
            if (!rx_s) begin
              state    <= DATA;
              bit_idx  <= '0;
              baud_cnt <= FULL_LOAD;
            end else begin
              // Line went back high before mid start bit: a glitch, not a frame
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end

        DATA: begin
          if (baud_cnt == '0) begin
            shreg[bit_idx] <= rx_s;
            baud_cnt       <= FULL_LOAD;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end

        STOP: begin
          if (baud_cnt == '0) begin
            if (rx_s) begin
              data_o  <= shreg;
              valid_o <= 1'b1;
              // Leaving at mid stop bit leaves half a bit to catch the next start edge
              state   <= IDLE;
            end else begin
`ifdef UART_RX_FRAME_ERR_EN
              frame_err_o <= 1'b1;
`endif
              state <= WAIT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end

        WAIT_IDLE: begin
          // A held-low line (break) must not be mistaken for a stream of start bits
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed frames checked against a frame-level reference model
`define CHECK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_uart_receiver;
  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err_o;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state: what the line carried, per frame
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] last_good;
  int         err_exp;

  // observations
  logic [7:0] got_q[$];
  int         got_t[$];
  int         err_got;
  logic       prev_valid;

  uart_receiver #(
    .CLOCKS_PER_BAUD(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_o     (data_o),
    .valid_o    (valid_o)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err_o(frame_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prev_valid = 1'b0;
    err_got    = 0;
  end

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      got_q.push_back(data_o);
      got_t.push_back(cyc);
      `CHECK("valid_not_back_to_back", prev_valid, 1'b0)
    end
    prev_valid = valid_o;
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err_o === 1'b1) err_got++;
`endif
  end

  // One 8N1 frame; stop_low > 0 holds the stop bit low that many cycles,
  // abort_bit >= 0 pulses rst in the middle of that data bit
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int abort_bit);
    int st;
    rx = 1'b0;
    st = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      for (int c = 0; c < CPB; c++) begin
        if (i == abort_bit && c == 5) rst = 1'b1;
        if (i == abort_bit && c == 7) rst = 1'b0;
        @(negedge clk);
      end
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    if (abort_bit >= 0) begin
      last_good = 8'h00;
    end else if (stop_low > 0) begin
      err_exp++;
    end else begin
      exp_q.push_back(b);
      exp_t.push_back(st);
      last_good = b;
    end
  endtask

  task automatic check_phase(input string name);
    int n;
    int lat;
    repeat (30) @(negedge clk);
    `CHECK({name, "_count"}, got_q.size(), exp_q.size())
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      `CHECK({name, "_data"}, got_q[i], exp_q[i])
      lat = got_t[i] - exp_t[i];
      `CHECK({name, "_latency_96_98"}, (lat >= 96 && lat <= 98), 1'b1)
    end
    `CHECK({name, "_data_hold"}, data_o, last_good)
`ifdef UART_RX_FRAME_ERR_EN
    `CHECK({name, "_frame_err_count"}, err_got, err_exp)
`endif
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    exp_t.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         gap;
    rx        = 1'b1;
    rst       = 1'b1;
    last_good = 8'h00;
    err_exp   = 0;
    repeat (5) @(negedge clk);
    `CHECK("reset_data", data_o, 8'h00)
    `CHECK("reset_valid", valid_o, 1'b0)
`ifdef UART_RX_FRAME_ERR_EN
    `CHECK("reset_frame_err", frame_err_o, 1'b0)
`endif
    rst = 1'b0;

    // steady idle line
    repeat (1000) @(negedge clk);
    check_phase("idle");

    send_frame(8'hFF, 0, -1);
    check_phase("ff");

    send_frame(8'h4D, 0, -1);
    send_frame(8'hA5, 0, -1);
    check_phase("b2b");

    // short low glitch, then a real frame
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_phase("glitch");
    send_frame(8'h3C, 0, -1);
    check_phase("after_glitch");

    // stop bit held low for two bit periods
    send_frame(8'h55, 2 * CPB, -1);
    check_phase("frame_err");
    send_frame(8'h12, 0, -1);
    check_phase("after_ferr");

    // reset mid data bit 4
    send_frame(8'hF0, 0, 4);
    check_phase("abort");
    send_frame(8'h81, 0, -1);
    check_phase("after_abort");

    // random frames with random gaps and occasional bad stop bits
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        send_frame(b, CPB, -1);
        repeat (12) @(negedge clk);
      end else begin
        send_frame(b, 0, -1);
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
      end
    end
    check_phase("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
